nrf24_spi_arbiter: RTL

//  Shares the single nRF24 SPI byte engine between NREQ requesters, e.g. the RX controller and a

---
 rtl/nrf24_pkg.sv | 13 +
 rtl/nrf24_rr_picker.sv | 29 ++
 rtl/nrf24_spi_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nrf24_pkg.sv
// Shared types for the nRF24 SPI arbitration slice.
// Arbiter FSM state encoding and the SPI byte width.
package nrf24_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/nrf24_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after i_ptr, wrapping.
// Zero latency, no backpressure; o_vld low when nothing requests.
module nrf24_rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_vld,
    output logic [IW-1:0]   o_idx
);

    logic [IW-1:0] w_j;

    // Scan from the farthest candidate back so the one nearest i_ptr wins.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        w_j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_j]) begin
                o_vld = 1'b1;
                o_idx = w_j;
            end
        end
    end

endmodule

// File: rtl/nrf24_spi_arbiter.sv
// Round-robin owner of the single nRF24 SPI byte engine for whole CSN-framed transactions.
// Grant 1 cycle after req; start/tx/done routed combinationally; a byte in flight holds the grant.
module nrf24_spi_arbiter
    import nrf24_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    output logic [NREQ-1:0]            gnt,
    input  logic [NREQ-1:0]            start,
    input  logic [NREQ*SPI_BYTE_W-1:0] tx_byte,
    input  logic [NREQ-1:0]            hold_csn,
    output logic [NREQ-1:0]            done,
    output logic [SPI_BYTE_W-1:0]      rx_byte,
    output logic                       m_start,
    output logic [SPI_BYTE_W-1:0]      m_tx,
    output logic                       m_hold_csn,
    input  logic                       m_done,
    input  logic [SPI_BYTE_W-1:0]      m_rx,
    output logic                       timeout,
    output logic                       proto_err
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t      r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_out;
    logic            r_timeout;
    logic [TW-1:0]   r_tmo;

    logic                  w_pick_vld;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_own_req;
    logic                  w_own_start;
    logic                  w_own_hold;
    logic [SPI_BYTE_W-1:0] w_own_tx;
    logic                  w_grant;
    logic                  w_active;
    logic                  w_tmo_hit;
    logic                  w_rel;
    logic                  w_drain;
    logic [IW-1:0]         w_next_ptr;

    nrf24_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    always_comb begin
        w_own_req   = 1'b0;
        w_own_start = 1'b0;
        w_own_hold  = 1'b0;
        w_own_tx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_req   = req[i];
                w_own_start = start[i];
                w_own_hold  = hold_csn[i];
                w_own_tx    = tx_byte[i*SPI_BYTE_W +: SPI_BYTE_W];
            end
        end
    end

    assign w_grant    = (r_state == ARB_GRANT);
    assign w_active   = w_grant | (r_state == ARB_DRAIN);
    assign m_start    = w_grant & w_own_start & ~r_out;
    assign proto_err  = w_grant & w_own_start & r_out;
    assign m_tx       = w_active ? w_own_tx : '0;
    assign m_hold_csn = w_active & w_own_hold;
    assign rx_byte    = m_rx;
    assign gnt        = r_gnt;
    assign timeout    = r_timeout;

    always_comb begin
        done = '0;
        for (int i = 0; i < NREQ; i++) begin
            done[i] = w_active & m_done & (r_owner == IW'(i));
        end
    end

    // A byte launched in the same cycle as the req drop still has to finish before release.
    assign w_drain    = w_grant & ~w_own_req & (m_start | (r_out & ~m_done));
    assign w_tmo_hit  = (TIMEOUT_CYC != 0) & w_grant & w_own_req & ~r_out & ~w_own_start
                        & (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_rel      = (w_grant & ~w_own_req & ~w_drain)
                        | w_tmo_hit
                        | ((r_state == ARB_DRAIN) & m_done);
    assign w_next_ptr = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_out     <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_timeout <= w_tmo_hit;
            if (m_start) begin
                r_out <= 1'b1;
            end else if (m_done) begin
                r_out <= 1'b0;
            end

            if (w_grant) begin
                if (w_own_start) begin
                    r_tmo <= '0;
                end else if (~r_out) begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end

            if (r_state == ARB_IDLE) begin
                if (w_pick_vld) begin
                    r_state <= ARB_GRANT;
                    r_owner <= w_pick_idx;
                    r_gnt   <= NREQ'(1) << w_pick_idx;
                end
            end else if (w_rel) begin
                r_state <= ARB_IDLE;
                r_gnt   <= '0;
                r_ptr   <= w_next_ptr;
            end else if (w_drain) begin
                r_state <= ARB_DRAIN;
            end
        end
    end

endmodule
